// File: rtl/query_pkg.sv
`default_nettype none
// Shared encodings for the queue geometry query port.
package query_pkg;

  localparam int QUERY_W = 32;

  localparam logic [1:0] DIM_QUEUE  = 2'd1;
  localparam logic [1:0] DIM_PACKED = 2'd2;

  typedef enum logic [3:0] {
    QF_LOW                 = 4'd0,
    QF_HIGH                = 4'd1,
    QF_LEFT                = 4'd2,
    QF_RIGHT               = 4'd3,
    QF_SIZE                = 4'd4,
    QF_INCREMENT           = 4'd5,
    QF_DIMENSIONS          = 4'd6,
    QF_UNPACKED_DIMENSIONS = 4'd7,
    QF_BITS                = 4'd8
  } query_func_e;

endpackage
`default_nettype wire

// File: rtl/queue_ring_store.sv
`default_nettype none
// Circular buffer with occupancy count, registered pop port and sticky
// overflow/underflow flags.
module queue_ring_store #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic [CNT_W-1:0] count_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop on a full queue frees the slot the same-cycle push lands in.
  always_comb begin
    pop_ok    = pop && (count != '0);
    push_ok   = push && ((count != FULL_CNT) || pop_ok);
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else if (clear) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_ok;
      if (pop_ok) begin
        pop_data <= mem[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/parametric_queue_query_unit.sv
`default_nettype none
// Bounded queue with a registered port answering array-query functions
// against the queue's live geometry.
module parametric_queue_query_unit
  import query_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_clear,
  input  logic                      in_push,
  input  logic [WIDTH-1:0]          in_push_data,
  input  logic                      in_pop,
  output logic                      out_pop_valid,
  output logic [WIDTH-1:0]          out_pop_data,
  output logic                      out_full,
  output logic                      out_empty,
  output logic                      out_overflow,
  output logic                      out_underflow,
  input  logic                      in_query_valid,
  input  logic [3:0]                in_query_func,
  input  logic [1:0]                in_query_dim,
  output logic                      out_resp_valid,
  output logic signed [QUERY_W-1:0] out_resp_value,
  output logic                      out_resp_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic signed [QUERY_W-1:0] ELEM_BITS = QUERY_W'(WIDTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("DEPTH must be at least 1");
  end
  if (longint'(DEPTH) * longint'(WIDTH) >= 64'sh8000_0000) begin : g_bits_check
    $error("DEPTH*WIDTH must be below 2^31");
  end

  logic [CNT_W-1:0]          count;
  logic signed [QUERY_W-1:0] n_s;
  logic signed [QUERY_W-1:0] q_value;
  logic                      q_err;
  logic                      dim_q;
  logic                      dim_p;

  queue_ring_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (in_clear),
    .push      (in_push),
    .push_data (in_push_data),
    .pop       (in_pop),
    .pop_valid (out_pop_valid),
    .pop_data  (out_pop_data),
    .full      (out_full),
    .empty     (out_empty),
    .overflow  (out_overflow),
    .underflow (out_underflow),
    .count     (count)
  );

  // Decoded from the pre-update count so a query sees the state before
  // any push/pop/clear of the same cycle.
  always_comb begin
    n_s     = signed'(QUERY_W'(count));
    dim_q   = (in_query_dim == DIM_QUEUE);
    dim_p   = (in_query_dim == DIM_PACKED);
    q_value = '0;
    q_err   = 1'b0;
    case (in_query_func)
      QF_LOW:                 q_value = '0;
      QF_HIGH:                q_value = dim_q ? n_s - 32'sd1 : ELEM_BITS - 32'sd1;
      QF_LEFT:                q_value = dim_q ? 32'sd0 : ELEM_BITS - 32'sd1;
      QF_RIGHT:               q_value = dim_q ? n_s - 32'sd1 : 32'sd0;
      QF_SIZE:                q_value = dim_q ? n_s : ELEM_BITS;
      QF_INCREMENT:           q_value = dim_q ? -32'sd1 : 32'sd1;
      QF_DIMENSIONS:          q_value = 32'sd2;
      QF_UNPACKED_DIMENSIONS: q_value = 32'sd1;
      QF_BITS:                q_value = n_s * ELEM_BITS;
      default:                q_err   = 1'b1;
    endcase
    if ((in_query_func <= 4'd5) && !dim_q && !dim_p) begin
      q_err = 1'b1;
    end
    if (q_err) begin
      q_value = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_resp_valid <= 1'b0;
      out_resp_value <= '0;
      out_resp_err   <= 1'b0;
    end else begin
      out_resp_valid <= in_query_valid;
      if (in_query_valid) begin
        out_resp_value <= q_value;
        out_resp_err   <= q_err;
      end
    end
  end

endmodule
`default_nettype wire
